// File: rtl/rwc_rsp_vote.sv
// Challenge/response wrapper around rwc_ctrl: runs NUM_ROUNDS generator rounds per challenge,
// majority-votes each response bit and flags bits that disagreed across rounds.
module rwc_rsp_vote #(
  parameter int NUM_ROUNDS = 7,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [9:0]  req_addr,
  output logic        gen_enable,
  output logic [31:0] gen_data,
  output logic [9:0]  gen_addr,
  input  logic        gen_available,
  input  logic [31:0] gen_rsp_write,
  input  logic [31:0] gen_rsp_clean,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_unstable,
  output logic        rsp_clean_err,
  output logic        rsp_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACCUM  = 3'd3;
  localparam logic [2:0] S_VOTE   = 3'd4;
  localparam logic [2:0] S_ABORT  = 3'd5;
  localparam logic [2:0] S_OUT    = 3'd6;

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(NUM_ROUNDS / 2);

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] round_reg;
  logic [WD_W-1:0]  wd_reg;
  logic             gen_enable_reg;
  logic [31:0]      gen_data_reg;
  logic [9:0]       gen_addr_reg;
  logic [31:0]      samp_write_reg;
  logic             samp_clean_nz_reg;
  logic             clean_err_reg;
  logic             rsp_valid_reg;
  logic [31:0]      rsp_data_reg;
  logic [31:0]      rsp_unstable_reg;
  logic             rsp_clean_err_reg;
  logic             rsp_timeout_reg;

  logic             accept;
  logic             wd_expired;
  logic [31:0]      maj_vec;
  logic [31:0]      unstable_vec;

  assign req_ready  = (state_reg == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign wd_expired = (wd_reg == WD_LAST);

  // Per-bit ones counters; wide enough for NUM_ROUNDS so they never wrap.
  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst || accept) begin
        cnt_reg <= '0;
      end else if (state_reg == S_ACCUM) begin
        cnt_reg <= cnt_reg + CNT_W'(samp_write_reg[gi]);
      end
    end

    assign maj_vec[gi]      = (cnt_reg > HALF_C);
    assign unstable_vec[gi] = (cnt_reg != '0) && (cnt_reg != ROUNDS_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      round_reg         <= '0;
      wd_reg            <= '0;
      gen_enable_reg    <= 1'b0;
      gen_data_reg      <= '0;
      gen_addr_reg      <= '0;
      samp_write_reg    <= '0;
      samp_clean_nz_reg <= 1'b0;
      clean_err_reg     <= 1'b0;
      rsp_valid_reg     <= 1'b0;
      rsp_data_reg      <= '0;
      rsp_unstable_reg  <= '0;
      rsp_clean_err_reg <= 1'b0;
      rsp_timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            gen_data_reg   <= req_data;
            gen_addr_reg   <= req_addr;
            round_reg      <= '0;
            clean_err_reg  <= 1'b0;
            wd_reg         <= '0;
            gen_enable_reg <= 1'b1;
            state_reg      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // The generator dropping available means it took the launch.
          if (!gen_available) begin
            gen_enable_reg <= 1'b0;
            wd_reg         <= '0;
            state_reg      <= S_WAIT;
          end else if (wd_expired) begin
            gen_enable_reg <= 1'b0;
            state_reg      <= S_ABORT;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        S_WAIT: begin
          if (gen_available) begin
            samp_write_reg    <= gen_rsp_write;
            samp_clean_nz_reg <= |gen_rsp_clean;
            state_reg         <= S_ACCUM;
          end else if (wd_expired) begin
            state_reg <= S_ABORT;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        S_ACCUM: begin
          clean_err_reg <= clean_err_reg | samp_clean_nz_reg;
          round_reg     <= round_reg + CNT_W'(1);
          if (round_reg + CNT_W'(1) == ROUNDS_C) begin
            state_reg <= S_VOTE;
          end else begin
            wd_reg         <= '0;
            gen_enable_reg <= 1'b1;
            state_reg      <= S_LAUNCH;
          end
        end
        S_VOTE: begin
          rsp_data_reg      <= maj_vec;
          rsp_unstable_reg  <= unstable_vec;
          rsp_clean_err_reg <= clean_err_reg;
          rsp_timeout_reg   <= 1'b0;
          rsp_valid_reg     <= 1'b1;
          state_reg         <= S_OUT;
        end
        S_ABORT: begin
          rsp_data_reg      <= '0;
          rsp_unstable_reg  <= '1;
          rsp_clean_err_reg <= clean_err_reg;
          rsp_timeout_reg   <= 1'b1;
          rsp_valid_reg     <= 1'b1;
          state_reg         <= S_OUT;
        end
        S_OUT: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          gen_enable_reg <= 1'b0;
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

  assign gen_enable    = gen_enable_reg;
  assign gen_data      = gen_data_reg;
  assign gen_addr      = gen_addr_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_data      = rsp_data_reg;
  assign rsp_unstable  = rsp_unstable_reg;
  assign rsp_clean_err = rsp_clean_err_reg;
  assign rsp_timeout   = rsp_timeout_reg;

endmodule

// File: tb/tb_rwc_rsp_vote.sv
// Bench for rwc_rsp_vote: behavioural generator model plus a per-bit vote reference model.
module tb_rwc_rsp_vote;

  localparam int N       = 7;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [9:0]  req_addr;
  logic        gen_enable;
  logic [31:0] gen_data;
  logic [9:0]  gen_addr;
  logic        gen_available = 1'b1;
  logic [31:0] gen_rsp_write = '0;
  logic [31:0] gen_rsp_clean = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_unstable;
  logic        rsp_clean_err;
  logic        rsp_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Generator model state
  logic [31:0] wr_tab [16];
  logic [31:0] cl_tab [16];
  int          gen_run     = 2;
  logic        gen_stuck   = 1'b0;
  int          busy        = 0;
  int          launches    = 0;
  int          launch_base = 0;
  int          run_idx     = 0;

  always #5 clk = ~clk;

  rwc_rsp_vote #(.NUM_ROUNDS(N), .CNT_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_addr(req_addr),
    .gen_enable(gen_enable), .gen_data(gen_data), .gen_addr(gen_addr),
    .gen_available(gen_available), .gen_rsp_write(gen_rsp_write), .gen_rsp_clean(gen_rsp_clean),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_unstable(rsp_unstable), .rsp_clean_err(rsp_clean_err), .rsp_timeout(rsp_timeout)
  );

  // rwc_ctrl stand-in: an enable seen while available starts one run of gen_run cycles,
  // after which available returns high with that round's table entry on the response buses.
  always @(posedge clk) begin
    if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        gen_available <= 1'b1;
        gen_rsp_write <= wr_tab[run_idx & 15];
        gen_rsp_clean <= cl_tab[run_idx & 15];
      end
    end else if (gen_available && gen_enable && !gen_stuck) begin
      gen_available <= 1'b0;
      busy          <= gen_run;
      run_idx       <= launches - launch_base;
      launches      <= launches + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: count the ones per bit over the rounds and decide by plain arithmetic.
  function automatic void ref_vote(output logic [31:0] d, output logic [31:0] u,
                                   output logic ce);
    ce = 1'b0;
    for (int r = 0; r < N; r++) if (cl_tab[r] != 0) ce = 1'b1;
    for (int b = 0; b < 32; b++) begin
      int ones = 0;
      for (int r = 0; r < N; r++) ones += int'(wr_tab[r][b]);
      d[b] = (2 * ones > N);
      u[b] = (ones != 0) && (ones != N);
    end
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send_req(input logic [31:0] d, input logic [9:0] a);
    int guard = 0;
    while (gen_available !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    launch_base = launches;
    req_valid = 1'b1;
    req_data  = d;
    req_addr  = a;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = $urandom;
    req_addr  = 10'($urandom);
    check("gen_data_latched", gen_data, d);
    check("gen_addr_latched", {22'd0, gen_addr}, {22'd0, a});
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_case(input string tag, input int run);
    logic [31:0] ed, eu;
    logic        ec;
    int          cyc;
    logic [31:0] d;
    d = $urandom;
    gen_run = run;
    send_req(d, 10'($urandom));
    wait_rsp(cyc);
    ref_vote(ed, eu, ec);
    check({tag, "_data"},     rsp_data, ed);
    check({tag, "_unstable"}, rsp_unstable, eu);
    check({tag, "_clean"},    {31'd0, rsp_clean_err}, {31'd0, ec});
    check({tag, "_timeout"},  {31'd0, rsp_timeout}, 32'd0);
    check({tag, "_launches"}, launches - launch_base, N);
    $display("[TB] %s run=%0d data=%08h unstable=%08h clean_err=%0b cycles=%0d",
             tag, run, rsp_data, rsp_unstable, rsp_clean_err, cyc);
    consume();
  endtask

  initial begin
    int          cyc;
    logic [31:0] cap_d, cap_u;
    logic        ok;
    rst = 1'b1; req_valid = 1'b0; req_data = '0; req_addr = '0; rsp_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin wr_tab[r] = '0; cl_tab[r] = '0; end
    repeat (3) @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
    check("rst_gen_enable", {31'd0, gen_enable}, 32'd0);
    check("rst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data",   rsp_data, 32'd0);
    check("rst_unstable",   rsp_unstable, 32'd0);
    check("rst_gen_data",   gen_data, 32'd0);
    check("rst_gen_addr",   {22'd0, gen_addr}, 32'd0);
    check("rst_flags",      {30'd0, rsp_clean_err, rsp_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Constant response every round
    for (int r = 0; r < N; r++) wr_tab[r] = 32'hA5A5_5A5A;
    run_case("const", 3);
    check("const_data_exact", rsp_data, 32'hA5A5_5A5A);

    // bit0 set in 4 of 7 rounds, bit1 in 3 of 7
    for (int r = 0; r < N; r++) wr_tab[r] = {30'd0, (r == 2 || r == 4 || r == 6), (r < 4)};
    run_case("split", 1);
    check("split_data_exact", rsp_data, 32'h0000_0001);
    check("split_unstable_exact", rsp_unstable, 32'h0000_0003);

    // Round 5 reports a dirty readback
    for (int r = 0; r < N; r++) wr_tab[r] = $urandom;
    cl_tab[4] = 32'h0000_0010;
    run_case("clean", 2);
    check("clean_err_set", {31'd0, rsp_clean_err}, 32'd1);
    cl_tab[4] = '0;

    // Randomized rounds: a base pattern with sparse per-round flips, occasional dirty reads
    for (int t = 0; t < 6; t++) begin
      logic [31:0] base;
      base = $urandom;
      for (int r = 0; r < N; r++) begin
        wr_tab[r] = base ^ ($urandom & $urandom & $urandom);
        cl_tab[r] = ($urandom_range(9, 0) == 0) ? $urandom : 32'd0;
      end
      run_case($sformatf("rand%0d", t), $urandom_range(4, 1));
    end
    for (int r = 0; r < 16; r++) cl_tab[r] = '0;

    // Generator never takes the launch
    gen_stuck = 1'b1;
    send_req($urandom, 10'($urandom));
    wait_rsp(cyc);
    check("to_latency_window", {31'd0, (cyc >= TIMEOUT && cyc <= TIMEOUT + 2)}, 32'd1);
    check("to_flag",     {31'd0, rsp_timeout}, 32'd1);
    check("to_data",     rsp_data, 32'd0);
    check("to_unstable", rsp_unstable, 32'hFFFF_FFFF);
    check("to_gen_enable_low", {31'd0, gen_enable}, 32'd0);
    $display("[TB] timeout cycles=%0d data=%08h unstable=%08h", cyc, rsp_data, rsp_unstable);
    consume();
    gen_stuck = 1'b0;

    // Back-pressure: outputs frozen while rsp_ready is low
    for (int r = 0; r < N; r++) wr_tab[r] = $urandom;
    gen_run = 2;
    send_req($urandom, 10'($urandom));
    wait_rsp(cyc);
    cap_d = rsp_data;
    cap_u = rsp_unstable;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ok = (rsp_data === cap_d) && (rsp_unstable === cap_u) && (rsp_valid === 1'b1) &&
           (req_ready === 1'b0);
      check("hold_stable", {31'd0, ok}, 32'd1);
    end
    $display("[TB] backpressure held data=%08h for 20 cycles", rsp_data);
    consume();

    // Reset during round 3 discards the request
    for (int r = 0; r < N; r++) wr_tab[r] = 32'hFFFF_FFFF;
    gen_run = 3;
    send_req($urandom, 10'($urandom));
    cyc = 0;
    while ((launches - launch_base) < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_round3", {31'd0, ((launches - launch_base) >= 3)}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_gen_enable", {31'd0, gen_enable}, 32'd0);
    check("midrst_idle",       {31'd0, req_ready}, 32'd1);
    check("midrst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || gen_enable !== 1'b0) ok = 1'b0;
    end
    check("midrst_no_result", {31'd0, ok}, 32'd1);
    $display("[TB] mid-request reset: stayed idle for 60 cycles");
    for (int r = 0; r < N; r++) wr_tab[r] = $urandom;
    run_case("after_rst", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
